// File: rtl/conv_kernel_pkg.sv
// Shared constants and helper functions for the convolution kernel engine.
package conv_kernel_pkg;

    localparam int DEF_DATA_W = 20;
    localparam int DEF_FRAC_W = 16;
    localparam int DEF_TAPS   = 9;
    localparam int DEF_BANKS  = 2;
    localparam int DEF_OUT_W  = 19;

    // Accumulator wide enough to sum TAPS full products plus the shifted bias.
    function automatic int acc_width(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps + 1);
    endfunction

    // Width of a bank selector; a single bank still gets a one-bit port.
    function automatic int sel_width(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

    // Half an LSB of the result, added before the arithmetic shift (round half up).
    function automatic longint round_const(input int frac_w);
        return (frac_w > 0) ? (64'sd1 <<< (frac_w - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/conv_kernel_engine_post.sv
// kernel_post: combinational round + range limiting of the accumulated sum.
// Build option KERNEL_RELU_EN selects ReLU with unsigned clipping; without it
// the result is a signed OUT_W value saturated at both ends.
module kernel_post
    import conv_kernel_pkg::*;
#(
    parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_TAPS),
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic signed [ACC_W-1:0] total,
    output logic        [OUT_W-1:0] data,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_const(FRAC_W));
    localparam logic signed [ACC_W-1:0] ONE = {{(ACC_W-1){1'b0}}, 1'b1};
`ifdef KERNEL_RELU_EN
    localparam logic signed [ACC_W-1:0] UMAX = (ONE <<< OUT_W) - ONE;
`else
    localparam logic signed [ACC_W-1:0] SMAX = (ONE <<< (OUT_W - 1)) - ONE;
    localparam logic signed [ACC_W-1:0] SMIN = -(ONE <<< (OUT_W - 1));
`endif

    logic signed [ACC_W-1:0] r;

    // Round to the output LSB, then clip to the representable range.
    always_comb begin
        r    = (total + RND) >>> FRAC_W;
        data = r[OUT_W-1:0];
        sat  = 1'b0;
`ifdef KERNEL_RELU_EN
        if (r[ACC_W-1]) begin
            data = '0;
        end else if (r > UMAX) begin
            data = '1;
            sat  = 1'b1;
        end
`else
        if (r > SMAX) begin
            data = SMAX[OUT_W-1:0];
            sat  = 1'b1;
        end else if (r < SMIN) begin
            data = SMIN[OUT_W-1:0];
            sat  = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/conv_kernel_engine.sv
// conv_kernel_engine: programmable TAPS-point signed dot product with bias,
// three-stage pipeline (multiply, partial sums, round/limit), valid/ready flow.
// Post-processing mode is chosen by KERNEL_RELU_EN inside kernel_post.
//
// Handshake: a sample transfers on a rising edge where i_valid && i_ready; a
// result transfers where o_valid && o_ready. The whole pipeline moves together
// under en = !o_valid || o_ready, so i_ready = en, bubbles are kept in place
// during a stall and the output registers hold while o_valid && !o_ready.
module conv_kernel_engine
    import conv_kernel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int BANKS  = DEF_BANKS,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_wload,
    input  logic [sel_width(BANKS)-1:0]   i_wbank,
    input  logic [$clog2(TAPS+1)-1:0]     i_waddr,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic [TAPS*DATA_W-1:0]        i_data,
    input  logic [sel_width(BANKS)-1:0]   i_sel,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [OUT_W-1:0]              o_data,
    output logic                          o_sat
);

    localparam int ACC_W = acc_width(DATA_W, TAPS);
    localparam int SW    = sel_width(BANKS);
    localparam int PW    = 2 * DATA_W;
    localparam int HALF  = TAPS / 2;

    // Per bank: entries 0..TAPS-1 are weights, entry TAPS is the bias.
    logic signed [DATA_W-1:0] coef [BANKS][TAPS+1];

    logic                    en;
    logic                    wr_ok;
    logic [SW-1:0]           bank;
    logic signed [PW-1:0]    prod_d [TAPS];
    logic signed [ACC_W-1:0] bias_d;

    logic                    v1;
    logic signed [PW-1:0]    prod_q [TAPS];
    logic signed [ACC_W-1:0] bias_q;

    logic                    v2;
    logic signed [ACC_W-1:0] sum_a, sum_b;
    logic signed [ACC_W-1:0] part_a, part_b;

    logic signed [ACC_W-1:0] total;
    logic [OUT_W-1:0]        post_data;
    logic                    post_sat;

    assign en      = !o_valid || o_ready;
    assign i_ready = en;
    assign wr_ok   = i_wload && (32'(i_wbank) < BANKS) && (32'(i_waddr) <= TAPS);

    // Coefficient store: independent of the stream, out-of-range writes dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < BANKS; b++)
                for (int a = 0; a <= TAPS; a++)
                    coef[b][a] <= '0;
        end else if (wr_ok) begin
            coef[i_wbank][i_waddr] <= i_wdata;
        end
    end

    // Bank lookup and tap products; the bias is aligned to the product scale.
    always_comb begin
        bank = (32'(i_sel) < BANKS) ? i_sel : '0;
        for (int k = 0; k < TAPS; k++)
            prod_d[k] = $signed(i_data[k*DATA_W +: DATA_W]) * coef[bank][k];
        bias_d = ACC_W'(coef[bank][TAPS]) <<< FRAC_W;
    end

    // Split the taps into two balanced sums; the bias rides with part A.
    always_comb begin
        sum_a = bias_q;
        sum_b = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (k < HALF) sum_a = sum_a + ACC_W'(prod_q[k]);
            else          sum_b = sum_b + ACC_W'(prod_q[k]);
        end
    end

    assign total = part_a + part_b;

    kernel_post #(
        .ACC_W  (ACC_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_post (
        .total (total),
        .data  (post_data),
        .sat   (post_sat)
    );

    // Three pipeline stages, all advancing together on en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1      <= 1'b0;
            bias_q  <= '0;
            for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
            v2      <= 1'b0;
            part_a  <= '0;
            part_b  <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sat   <= 1'b0;
        end else if (en) begin
            v1      <= i_valid;
            prod_q  <= prod_d;
            bias_q  <= bias_d;
            v2      <= v1;
            part_a  <= sum_a;
            part_b  <= sum_b;
            o_valid <= v2;
            o_data  <= post_data;
            o_sat   <= post_sat;
        end
    end

endmodule
